// File: rtl/multi_reg_bank.sv
// multi_reg_bank
// NCH independent WIDTH-bit live registers with per-channel load and ring
// rotation, plus a shadow register set with per-channel dirty tracking. A
// sequenced commit copies dirty shadow entries into the live registers, one
// channel per cycle, so that a group of updates appears as one staged step.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   mode_i         live op: 00 hold, 01 load, 10 rotate up, 11 rotate down
//   ld_en_i        per-channel load enable (mode 01)
//   d_i            parallel load data, channel i at [i*WIDTH +: WIDTH]
//   sh_we_i        shadow write strobe
//   sh_addr_i      shadow channel select
//   sh_wdata_i     shadow write data
//   commit_i       request copy of dirty shadow entries into live registers
//   q_o            live register contents, same packing as d_i
//   dirty_o        shadow entry written since its last commit
//   busy_o         commit sequence in progress
//   commit_done_o  one-cycle pulse at commit completion
module multi_reg_bank #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           mode_i,
  input  logic [NCH-1:0]       ld_en_i,
  input  logic [NCH*WIDTH-1:0] d_i,
  input  logic                 sh_we_i,
  input  logic [$clog2(NCH)-1:0] sh_addr_i,
  input  logic [WIDTH-1:0]     sh_wdata_i,
  input  logic                 commit_i,
  output logic [NCH*WIDTH-1:0] q_o,
  output logic [NCH-1:0]       dirty_o,
  output logic                 busy_o,
  output logic                 commit_done_o
);

  localparam int AW = $clog2(NCH);
  // One extra bit so the channel count itself is representable.
  localparam logic [AW:0]   NCH_L  = (AW+1)'(NCH);
  localparam logic [AW-1:0] LAST_L = AW'(NCH - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] q_q [NCH];
  logic [WIDTH-1:0] q_d [NCH];
  logic [WIDTH-1:0] s_q [NCH];
  logic [WIDTH-1:0] s_d [NCH];
  logic [NCH-1:0]   dirty_q, dirty_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sh_valid;

  // Out-of-range addresses only exist when NCH is not a power of two.
  assign sh_valid = sh_we_i && ({1'b0, sh_addr_i} < NCH_L);

  // Next-state logic: FSM, live ops, commit copy and shadow writes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dirty_d = dirty_q;
    done_d  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      q_d[i] = q_q[i];
      s_d[i] = s_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (commit_i) begin
          // Commit has priority over the live op in this cycle.
          if (|dirty_q) begin
            state_d = ST_COMMIT;
            ptr_d   = {AW{1'b0}};
          end else begin
            done_d  = 1'b1;
          end
        end else begin
          case (mode_i)
            2'b00: begin
              for (int i = 0; i < NCH; i++) q_d[i] = q_q[i];
            end
            2'b01: begin
              for (int i = 0; i < NCH; i++) begin
                if (ld_en_i[i]) begin
                  q_d[i] = d_i[i*WIDTH +: WIDTH];
                end else begin
                  q_d[i] = q_q[i];
                end
              end
            end
            2'b10: begin
              for (int i = 0; i < NCH; i++) q_d[i] = q_q[(i + NCH - 1) % NCH];
            end
            2'b11: begin
              for (int i = 0; i < NCH; i++) q_d[i] = q_q[(i + 1) % NCH];
            end
            default: begin
              for (int i = 0; i < NCH; i++) q_d[i] = q_q[i];
            end
          endcase
        end
      end
      ST_COMMIT: begin
        // Clean channels are skipped but still take their cycle, so the
        // sequence length never depends on how many entries are dirty.
        if (dirty_q[ptr_q]) begin
          q_d[ptr_q]     = s_q[ptr_q];
          dirty_d[ptr_q] = 1'b0;
        end else begin
          q_d[ptr_q]     = q_q[ptr_q];
        end
        if (ptr_q == LAST_L) begin
          state_d = ST_IDLE;
          ptr_d   = {AW{1'b0}};
          done_d  = 1'b1;
        end else begin
          ptr_d   = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = {AW{1'b0}};
      end
    endcase

    // Applied last so a write colliding with the commit copy keeps the
    // entry dirty; the copy above already used the old shadow value.
    if (sh_valid) begin
      s_d[sh_addr_i]     = sh_wdata_i;
      dirty_d[sh_addr_i] = 1'b1;
    end else begin
      dirty_d = dirty_d;
    end

    busy_d = (state_d == ST_COMMIT);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= {AW{1'b0}};
      dirty_q <= {NCH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        q_q[i] <= {WIDTH{1'b0}};
        s_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dirty_q <= dirty_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < NCH; i++) begin
        q_q[i] <= q_d[i];
        s_q[i] <= s_d[i];
      end
    end
  end

  // Pack the live registers onto the output bus.
  always_comb begin
    q_o = {(NCH*WIDTH){1'b0}};
    for (int i = 0; i < NCH; i++) q_o[i*WIDTH +: WIDTH] = q_q[i];
  end

  assign dirty_o       = dirty_q;
  assign busy_o        = busy_q;
  assign commit_done_o = done_q;

endmodule

// File: tb/tb_multi_reg_bank.sv
// Directed and randomised checks for multi_reg_bank (WIDTH=8, NCH=4).
module tb_multi_reg_bank;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [3:0]  ld_en;
  logic [31:0] d;
  logic        sh_we;
  logic [1:0]  sh_addr;
  logic [7:0]  sh_wdata;
  logic        commit;
  logic [31:0] q;
  logic [3:0]  dirty;
  logic        busy;
  logic        commit_done;

  int errors = 0;
  int checks = 0;

  multi_reg_bank #(.WIDTH(8), .NCH(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mode_i        (mode),
    .ld_en_i       (ld_en),
    .d_i           (d),
    .sh_we_i       (sh_we),
    .sh_addr_i     (sh_addr),
    .sh_wdata_i    (sh_wdata),
    .commit_i      (commit),
    .q_o           (q),
    .dirty_o       (dirty),
    .busy_o        (busy),
    .commit_done_o (commit_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] eq, input logic [3:0] ed,
                         input logic eb, input logic ec);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".dirty"}, {28'd0, dirty}, {28'd0, ed});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".done"}, {31'd0, commit_done}, {31'd0, ec});
  endtask

  // Reference model state for the random phase
  logic [7:0] mq [4];
  logic [7:0] ms [4];
  logic [3:0] md;
  logic       mbusy;
  logic       mdone;
  int         mptr;

  initial begin
    logic [7:0] nq [4];
    rst = 1'b1; mode = 2'b00; ld_en = 4'h0; d = 32'h0;
    sh_we = 1'b0; sh_addr = 2'd0; sh_wdata = 8'h00; commit = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_all("reset", 32'h0000_0000, 4'b0000, 1'b0, 1'b0);

    // Load and rotate
    mode = 2'b01; ld_en = 4'b0101; d = 32'h281E_140A;
    step();
    chk("load.q", q, 32'h001E_000A);
    mode = 2'b10; step();
    chk("rot_up.q", q, 32'h1E00_0A00);
    mode = 2'b11; step();
    chk("rot_dn.q", q, 32'h001E_000A);
    mode = 2'b00; ld_en = 4'h0; d = 32'h0;

    // Shadow writes then a commit
    sh_we = 1'b1; sh_addr = 2'd1; sh_wdata = 8'h21; step();
    chk("sh1.dirty", {28'd0, dirty}, 32'h2);
    sh_addr = 2'd3; sh_wdata = 8'h17; step();
    sh_we = 1'b0;
    chk_all("sh3", 32'h001E_000A, 4'b1010, 1'b0, 1'b0);
    commit = 1'b1; step();
    commit = 1'b0;
    chk_all("cm_t0", 32'h001E_000A, 4'b1010, 1'b1, 1'b0);
    step();
    chk_all("cm_t1", 32'h001E_000A, 4'b1010, 1'b1, 1'b0);
    step();
    chk_all("cm_t2", 32'h001E_210A, 4'b1000, 1'b1, 1'b0);
    step();
    chk_all("cm_t3", 32'h001E_210A, 4'b1000, 1'b1, 1'b0);
    step();
    chk_all("cm_t4", 32'h171E_210A, 4'b0000, 1'b0, 1'b1);
    step();
    chk_all("cm_t5", 32'h171E_210A, 4'b0000, 1'b0, 1'b0);

    // Collision on ch1 while it is being committed
    sh_we = 1'b1; sh_addr = 2'd1; sh_wdata = 8'h05; step();
    sh_we = 1'b0;
    commit = 1'b1; step();
    commit = 1'b0;
    step();
    sh_we = 1'b1; sh_addr = 2'd1; sh_wdata = 8'h09; step();
    sh_we = 1'b0;
    chk_all("col_t2", 32'h171E_050A, 4'b0010, 1'b1, 1'b0);
    step();
    step();
    chk_all("col_end", 32'h171E_050A, 4'b0010, 1'b0, 1'b1);
    // A second commit shows the shadow kept the colliding write
    commit = 1'b1; step();
    commit = 1'b0;
    step(); step(); step(); step();
    chk_all("col_re", 32'h171E_090A, 4'b0000, 1'b0, 1'b1);

    // Empty commit
    commit = 1'b1; step();
    commit = 1'b0;
    chk_all("empty_t0", 32'h171E_090A, 4'b0000, 1'b0, 1'b1);
    step();
    chk_all("empty_t1", 32'h171E_090A, 4'b0000, 1'b0, 1'b0);

    // Live inputs ignored on the commit cycle and during COMMIT
    sh_we = 1'b1; sh_addr = 2'd2; sh_wdata = 8'h33; step();
    sh_we = 1'b0;
    commit = 1'b1; mode = 2'b01; ld_en = 4'hF; d = 32'hFFFF_FFFF; step();
    commit = 1'b0;
    chk("ign_t0.q", q, 32'h171E_090A);
    step(); step(); step();
    chk("ign_t3.busy", {31'd0, busy}, 32'h1);
    step();
    chk_all("ign_end", 32'h1733_090A, 4'b0000, 1'b0, 1'b1);
    mode = 2'b00; ld_en = 4'h0; d = 32'h0;

    // Reset mid-commit at ptr=2
    sh_we = 1'b1; sh_addr = 2'd0; sh_wdata = 8'h44; step();
    sh_addr = 2'd3; sh_wdata = 8'h55; step();
    sh_we = 1'b0;
    commit = 1'b1; step();
    commit = 1'b0;
    step(); step();
    chk("mid.q", q, 32'h1733_0944);
    rst = 1'b1; step();
    rst = 1'b0;
    chk_all("rst_mid", 32'h0000_0000, 4'b0000, 1'b0, 1'b0);
    step();
    chk_all("rst_after", 32'h0000_0000, 4'b0000, 1'b0, 1'b0);

    // Random phase against a reference model
    for (int k = 0; k < 4; k++) begin mq[k] = 8'h00; ms[k] = 8'h00; end
    md = 4'h0; mbusy = 1'b0; mdone = 1'b0; mptr = 0;
    for (int c = 0; c < 2000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      mode     = 2'($urandom_range(0, 3));
      ld_en    = 4'($urandom_range(0, 15));
      d        = $urandom;
      sh_we    = 1'($urandom_range(0, 1));
      sh_addr  = 2'($urandom_range(0, 3));
      sh_wdata = 8'($urandom_range(0, 255));
      commit   = ($urandom_range(0, 7) == 0);

      mdone = 1'b0;
      if (rst) begin
        for (int k = 0; k < 4; k++) begin mq[k] = 8'h00; ms[k] = 8'h00; end
        md = 4'h0; mbusy = 1'b0; mptr = 0;
      end else begin
        for (int k = 0; k < 4; k++) nq[k] = mq[k];
        if (mbusy) begin
          if (md[mptr]) begin
            nq[mptr] = ms[mptr];
            md[mptr] = 1'b0;
          end
          if (mptr == 3) begin
            mbusy = 1'b0; mdone = 1'b1; mptr = 0;
          end else begin
            mptr = mptr + 1;
          end
        end else if (commit) begin
          if (md != 4'h0) begin mbusy = 1'b1; mptr = 0; end
          else mdone = 1'b1;
        end else if (mode == 2'b01) begin
          for (int k = 0; k < 4; k++) if (ld_en[k]) nq[k] = d[k*8 +: 8];
        end else if (mode == 2'b10) begin
          for (int k = 0; k < 4; k++) nq[k] = mq[(k + 3) % 4];
        end else if (mode == 2'b11) begin
          for (int k = 0; k < 4; k++) nq[k] = mq[(k + 1) % 4];
        end
        for (int k = 0; k < 4; k++) mq[k] = nq[k];
        if (sh_we) begin
          ms[sh_addr] = sh_wdata;
          md[sh_addr] = 1'b1;
        end
      end

      step();
      chk_all("rand", {mq[3], mq[2], mq[1], mq[0]}, md, mbusy, mdone);
    end

    rst = 1'b0; sh_we = 1'b0; commit = 1'b0; mode = 2'b00;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_reg_bank.md
# multi_reg_bank

Parametrised successor to the team's twin 8-bit register set: `NCH` independent `WIDTH`-bit live registers with per-channel load enables and ring-rotate modes. Adds a shadow register set with per-channel dirty tracking, written one channel at a time. A sequenced commit copies the dirty shadow entries into the live registers, one channel per cycle. It serves as the generic staged-configuration register bank for datapath blocks that need atomic-looking multi-register updates.

## Interface
- `WIDTH`, 8, bits per channel (≥1)
- `NCH`, 4, channel count (≥2); `AW = $clog2(NCH)` is derived, not overridable

- `clk`  in  1  rising-edge clock, only clock domain
- `rst`  in  1  synchronous, active-high reset
- `mode`  in  2  live op: 00 hold, 01 load, 10 rotate up, 11 rotate down
- `ld_en`  in  NCH  per-channel load enable, used when mode=01
- `d`  in  NCH*WIDTH  parallel load data, channel i at `[i*WIDTH +: WIDTH]`
- `sh_we`  in  1  shadow write strobe
- `sh_addr`  in  AW  shadow channel select
- `sh_wdata`  in  WIDTH  shadow write data
- `commit`  in  1  request copy of dirty shadow entries into live registers
- `q`  out  NCH*WIDTH  live register contents, same packing as `d`
- `dirty`  out  NCH  shadow entry i written since its last commit
- `busy`  out  1  commit sequence in progress
- `commit_done`  out  1  one-cycle pulse at commit completion

## Operation
- State: live `q[i]`, shadow `s[i]`, `dirty[i]`, FSM {IDLE, COMMIT}, pointer `ptr` (AW bits). All outputs are registered.
- Reset clears all registers and returns the FSM to IDLE. Reset values: `q`=0, `s`=0, `dirty`=0, `busy`=0, `commit_done`=0. Reset applies at any time, including mid-commit, and wins over all other inputs.

**IDLE, commit=0:** apply `mode`.
- 00 hold: no change.
- 01 load: `q[i]<=d[i]` where `ld_en[i]`; other channels hold.
- 10 rotate up: `q[i]<=q[i-1]`, `q[0]<=q[NCH-1]`.
- 11 rotate down: `q[i]<=q[i+1]`, `q[NCH-1]<=q[0]`.

**IDLE, commit=1:** `commit` has priority and `mode` is ignored that cycle.
- If any `dirty` bit is set: go to COMMIT with `ptr`=0.
- Otherwise: stay in IDLE and pulse `commit_done`.

**COMMIT:** each cycle handles channel `ptr`.
- If `dirty[ptr]`: `q[ptr]<=s[ptr]` and clear `dirty[ptr]`.
- Clean channels are skipped in place; they still consume a cycle.
- `ptr` increments each cycle. After handling `ptr=NCH-1`, go to IDLE and pulse `commit_done`.
- `mode`, `ld_en`, `d` and `commit` are ignored while in COMMIT.

**Shadow writes:** accepted in both states. `sh_we` sets `s[sh_addr]<=sh_wdata` and `dirty[sh_addr]<=1`.
- `sh_addr ≥ NCH` (non-power-of-2 `NCH`): the write is dropped and no dirty bit changes.
- Shadow write to the channel being committed in the same cycle: the copy uses the old `s[ptr]`. `s[ptr]` takes the new data and `dirty[ptr]` ends 1, because the set wins over the clear.
- Shadow write to a channel already committed in this sequence: that channel stays dirty for the next commit.
- Shadow write to a channel not yet reached: the new data is copied when `ptr` reaches it.

## Timing
- Live ops: `q` reflects the mode-01/10/11 result after the sampling edge, so latency is 1 cycle.
- Shadow write: `dirty` and `s` are updated 1 cycle after the `sh_we` edge.

**Commit with dirty bits**, `commit` sampled at edge t:
- `busy`=1 after edge t.
- Channel k is handled at edge t+1+k; the copy is visible after that edge.
- After edge t+NCH: `busy`=0 and `commit_done`=1 for exactly one cycle.
- Total occupancy is NCH cycles, independent of the dirty count.

**Commit with no dirty bits:** after edge t, `commit_done`=1 for one cycle and `busy` stays 0.

**Back-to-back:** a `commit` held high in the `commit_done` cycle starts a new sequence, provided a bit is dirty.

## Test plan
All scenarios use WIDTH=8, NCH=4.

1. Reset mid-commit: `rst`=1 during COMMIT at `ptr`=2 -> next cycle `q`=0, `dirty`=0, `busy`=0, `commit_done`=0, FSM in IDLE.
2. Load and rotate: mode=01, `ld_en`=4'b0101, d={40,30,20,10} (ch3..ch0) -> `q`={0,30,0,10}. Then mode=10 for one cycle -> `q`={30,0,10,0}. Then mode=11 for one cycle -> `q` returns to {0,30,0,10}.
3. Commit: shadow writes ch1=0x21 and ch3=0x17 -> `dirty`=4'b1010. Assert `commit` -> `busy` high for 4 cycles, `q[1]`=0x21 after edge t+2, `q[3]`=0x17 after edge t+4, `commit_done` pulses once, `dirty`=0.
4. Collision: during COMMIT at `ptr`=1 with ch1 dirty (s=0x05), `sh_we` ch1=0x09 -> `q[1]`=0x05, `s[1]`=0x09, `dirty[1]`=1 after the sequence ends.
5. Empty commit and ignored inputs: `commit` with `dirty`=0 -> `commit_done` pulses the next cycle, `busy` never rises. Separately, mode=01 with all `ld_en` set during COMMIT -> no live change beyond the commit copies.
6. Random: 2000 cycles of random `mode`, `ld_en`, `d`, shadow writes and commits, compared cycle-by-cycle against a reference model on `q`, `dirty`, `busy` and `commit_done`.
